lpc_model_store: RTL
====================

// Module: lpc_model_store
// PURPOSE
//  LPC predictor-coefficient store for the Levinson-Durbin recursion stage.
//  Answers the model selector's paired reads (oSel1/oSel2 -> model values),
//  accepts its delayed paired write-backs (oTarget1/2 + oNewModel1/2, oOnlyOne, oValid)
//  and takes the reflection-coefficient insert a[m] = km for each iteration.
//  After the last iteration it streams coefficients 1..order to the quantiser.
//  Entry 0 is fixed at 1.0f.
// PARAMETERS
//  ORDER   12  highest coefficient index held (entries 0..ORDER)
//  DATA_W  32  IEEE-754 single-precision word width
//  ADDR_W  4   index width; must satisfy 2**ADDR_W > ORDER
// PORTS
//  iClock       in   1       rising-edge clock, the only clock
//  iReset_n     in   1       asynchronous, active-low reset
//  iClear       in   1       start a new LPC run: reinitialise all entries
//  iSel1        in   ADDR_W  read index, port 1
//  iSel2        in   ADDR_W  read index, port 2
//  oModel1      out  DATA_W  registered data for iSel1
//  oModel2      out  DATA_W  registered data for iSel2
//  iWrite       in   1       paired write strobe (the selector's valid)
//  iOnlyOne     in   1       write port 1 only
//  iTarget1     in   ADDR_W  write index, port 1
//  iTarget2     in   ADDR_W  write index, port 2
//  iData1       in   DATA_W  write data, port 1
//  iData2       in   DATA_W  write data, port 2
//  iInsertEn    in   1       write iInsertData to iInsertAddr (a[m] = km)
//  iInsertAddr  in   ADDR_W  insert index
//  iInsertData  in   DATA_W  insert data
//  iDumpStart   in   1       begin streaming coefficients out
//  iDumpOrder   in   ADDR_W  last index to stream
//  oDumpData    out  DATA_W  streamed coefficient
//  oDumpIdx     out  ADDR_W  index of oDumpData
//  oDumpValid   out  1       oDumpData/oDumpIdx are valid
//  oDumpDone    out  1       one-cycle pulse coinciding with the last beat
//  oBusy        out  1       high in CLEAR or DUMP
// BEHAVIOUR
//  Reset (async, iReset_n=0)
//   - State READY.
//   - Entry 0 = 32'h3F800000; entries 1..ORDER = 0.
//   - All outputs = 0.
//  States and transitions
//   - READY -> CLEAR on iClear.
//   - READY -> DUMP on iDumpStart.
//   - CLEAR -> READY after the clear sweep completes.
//   - DUMP -> READY after the last beat.
//   - iClear in any state -> CLEAR; an active dump is aborted and oDumpDone does not pulse.
//  CLEAR
//   - Zeroes one entry per cycle, indices 1..ORDER: ORDER cycles, then READY.
//   - Entry 0 is rewritten to 1.0f.
//   - Writes and inserts are ignored.
//  Reads (all states)
//   - oModelX <= entry[iSelX] one cycle after iSelX is presented.
//   - Index > ORDER reads 0.
//   - Read-first: a same-cycle write to the same index returns the old value.
//  Writes (READY only)
//   - On iWrite: entry[iTarget1] <= iData1.
//   - Also entry[iTarget2] <= iData2 unless iOnlyOne is set.
//   - iTarget1 == iTarget2 with iOnlyOne=0: port 1 wins.
//   - Index 0 or index > ORDER: that write is dropped.
//  Insert (READY only)
//   - On iInsertEn: entry[iInsertAddr] <= iInsertData, with the same index rules as writes.
//   - Insert beats a same-cycle paired write to the same index.
//  DUMP
//   - Order latched at start and clamped to ORDER.
//   - Starting one cycle after iDumpStart, one beat per cycle for idx = 1..order:
//     oDumpValid=1, oDumpIdx=idx, oDumpData=entry[idx].
//   - oDumpDone=1 on the final beat.
//   - Order 0: no valid beat; oDumpDone pulses alone one cycle after start.
//   - Writes, inserts and iDumpStart are ignored while in DUMP.
//  Outputs
//   - oDump* are 0 whenever not beating.
//   - oBusy rises the cycle after entry to CLEAR/DUMP and falls the cycle after return to READY.
// TESTING
//  1. Reset then read sel 0 and sel 5 -> next cycle oModel1=3F800000, oModel2=0.
//  2. iClear -> oBusy high for 12 cycles; earlier-written entry 3 reads 0 afterwards.
//  3. iWrite, T1=2, T2=4, D1=40000000, D2=40400000 -> reads return those values.
//     Same with iOnlyOne=1 -> entry 4 is unchanged.
//  4. Same-cycle collisions:
//     - Insert and write both to index 3 -> insert data wins.
//     - Write to index 0 -> entry 0 stays 1.0.
//     - Read of index 2 during a write to 2 -> returns the old value.
//  5. Dump order 3 -> three beats, idx 1,2,3, with correct data; oDumpDone on beat 3.
//     Order 0 -> done pulse only. Order 15 -> clamped to 12 beats.
//  6. iClear asserted mid-dump, and iReset_n pulsed mid-write:
//     - Dump stops with no oDumpDone.
//     - Reset values hold immediately, without waiting for a clock.

Source files
------------

// File: rtl/lpc_model_store.sv
// LPC predictor-coefficient store: paired reads, paired write-backs, a[m]=km inserts,
// a per-entry clear sweep and a coefficient dump stream for the quantiser.
module lpc_model_store #(
    parameter int ORDER  = 12,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              iClock,
    input  logic              iReset_n,
    input  logic              iClear,
    input  logic [ADDR_W-1:0] iSel1,
    input  logic [ADDR_W-1:0] iSel2,
    output logic [DATA_W-1:0] oModel1,
    output logic [DATA_W-1:0] oModel2,
    input  logic              iWrite,
    input  logic              iOnlyOne,
    input  logic [ADDR_W-1:0] iTarget1,
    input  logic [ADDR_W-1:0] iTarget2,
    input  logic [DATA_W-1:0] iData1,
    input  logic [DATA_W-1:0] iData2,
    input  logic              iInsertEn,
    input  logic [ADDR_W-1:0] iInsertAddr,
    input  logic [DATA_W-1:0] iInsertData,
    input  logic              iDumpStart,
    input  logic [ADDR_W-1:0] iDumpOrder,
    output logic [DATA_W-1:0] oDumpData,
    output logic [ADDR_W-1:0] oDumpIdx,
    output logic              oDumpValid,
    output logic              oDumpDone,
    output logic              oBusy
);

    localparam logic [DATA_W-1:0] ONE_F   = DATA_W'(32'h3F80_0000);
    localparam logic [ADDR_W-1:0] ORDER_A = ADDR_W'(ORDER);
    localparam logic [ADDR_W:0]   ORDER_C = (ADDR_W + 1)'(ORDER);

    typedef enum logic [1:0] {S_READY, S_CLEAR, S_DUMP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] ord_q, ord_d;
    logic [ADDR_W-1:0] start_ord;
    logic [DATA_W-1:0] mem_q [1:ORDER];
    logic [DATA_W-1:0] mem_d [1:ORDER];
    logic [DATA_W-1:0] model1_q, model1_d, model2_q, model2_d;
    logic [DATA_W-1:0] dump_data_q, dump_data_d;
    logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_done_q, dump_done_d;
    logic              busy_q, busy_d;

    // Entry 0 is never writable, so it is a constant rather than storage.
    function automatic logic [DATA_W-1:0] rd_entry(input logic [ADDR_W-1:0] idx);
        if (idx == '0)     return ONE_F;
        if (idx > ORDER_A) return '0;
        return mem_q[idx];
    endfunction

    function automatic logic wr_ok(input logic [ADDR_W-1:0] idx);
        return (idx != '0) && (idx <= ORDER_A);
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ord_d        = ord_q;
        mem_d        = mem_q;
        model1_d     = rd_entry(iSel1);
        model2_d     = rd_entry(iSel2);
        dump_data_d  = '0;
        dump_idx_d   = '0;
        dump_valid_d = 1'b0;
        dump_done_d  = 1'b0;
        busy_d       = (state_q != S_READY);
        start_ord    = (iDumpOrder > ORDER_A) ? ORDER_A : iDumpOrder;

        if (iClear) begin
            state_d = S_CLEAR;
            cnt_d   = (ADDR_W + 1)'(1);
        end else begin
            case (state_q)
                S_READY: begin
                    // First beat leaves on the start edge; cnt then tracks the next index.
                    if (iDumpStart) begin
                        state_d = S_DUMP;
                        ord_d   = start_ord;
                        cnt_d   = (ADDR_W + 1)'(2);
                        if (start_ord == '0) begin
                            dump_done_d = 1'b1;
                        end else begin
                            dump_valid_d = 1'b1;
                            dump_idx_d   = ADDR_W'(1);
                            dump_data_d  = rd_entry(ADDR_W'(1));
                            dump_done_d  = (start_ord == ADDR_W'(1));
                        end
                    end
                    // Later assignments win: port 2, then port 1, then the insert.
                    if (iWrite && !iOnlyOne && wr_ok(iTarget2)) mem_d[iTarget2] = iData2;
                    if (iWrite && wr_ok(iTarget1))               mem_d[iTarget1] = iData1;
                    if (iInsertEn && wr_ok(iInsertAddr))         mem_d[iInsertAddr] = iInsertData;
                end
                S_CLEAR: begin
                    mem_d[cnt_q[ADDR_W-1:0]] = '0;
                    if (cnt_q == ORDER_C) state_d = S_READY;
                    else                  cnt_d = cnt_q + 1'b1;
                end
                S_DUMP: begin
                    if (cnt_q > {1'b0, ord_q}) begin
                        state_d = S_READY;
                    end else begin
                        dump_valid_d = 1'b1;
                        dump_idx_d   = cnt_q[ADDR_W-1:0];
                        dump_data_d  = rd_entry(cnt_q[ADDR_W-1:0]);
                        dump_done_d  = (cnt_q == {1'b0, ord_q});
                        cnt_d        = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_READY;
            endcase
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q      <= S_READY;
            cnt_q        <= '0;
            ord_q        <= '0;
            for (int i = 1; i <= ORDER; i++) mem_q[i] <= '0;
            model1_q     <= '0;
            model2_q     <= '0;
            dump_data_q  <= '0;
            dump_idx_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ord_q        <= ord_d;
            mem_q        <= mem_d;
            model1_q     <= model1_d;
            model2_q     <= model2_d;
            dump_data_q  <= dump_data_d;
            dump_idx_q   <= dump_idx_d;
            dump_valid_q <= dump_valid_d;
            dump_done_q  <= dump_done_d;
            busy_q       <= busy_d;
        end
    end

    assign oModel1    = model1_q;
    assign oModel2    = model2_q;
    assign oDumpData  = dump_data_q;
    assign oDumpIdx   = dump_idx_q;
    assign oDumpValid = dump_valid_q;
    assign oDumpDone  = dump_done_q;
    assign oBusy      = busy_q;

endmodule
